inv_rotator: RTL and testbench

Inverse rho step for the Keccak decoder path. It takes one 64-bit lane and its lane index, then rotates the lane RIGHT by that lane's rho offset, which undoes the encoder's left rotation. The default build is serial: a 64-bit circular shift register plus a down-counter, with a start/busy/done handshake to the decoder controller. It sits between the decoder's state-array lane mux and the inverse-pi stage.

---
 rtl/inv_rotator.sv | 112 +++++++++++
 tb/tb_inv_rotator.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/inv_rotator.sv
// Inverse Keccak rho: rotates one lane right by its rho offset (serial by default).
// Define INV_ROTATOR_BARREL_EN to replace the serial shifter with a one-cycle barrel rotator.
module inv_rotator #(
  parameter int unsigned LANE_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LANE_W-1:0] lane,
  input  logic [4:0]        l_n,
  output logic              busy,
  output logic              done,
  output logic [5:0]        offset,
  output logic [LANE_W-1:0] rotated
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [LANE_W-1:0] shreg_q, shreg_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [5:0]        offset_q, offset_d;
  logic [5:0]        rom_raw;
  logic [5:0]        rom_off;

  // Rho offset ROM indexed by 5y+x; indices past 24 pass the lane through.
  always_comb begin
    rom_raw = 6'd0;
    case (l_n)
      5'd0:  rom_raw = 6'd0;
      5'd1:  rom_raw = 6'd1;
      5'd2:  rom_raw = 6'd62;
      5'd3:  rom_raw = 6'd28;
      5'd4:  rom_raw = 6'd27;
      5'd5:  rom_raw = 6'd36;
      5'd6:  rom_raw = 6'd44;
      5'd7:  rom_raw = 6'd6;
      5'd8:  rom_raw = 6'd55;
      5'd9:  rom_raw = 6'd20;
      5'd10: rom_raw = 6'd3;
      5'd11: rom_raw = 6'd10;
      5'd12: rom_raw = 6'd43;
      5'd13: rom_raw = 6'd25;
      5'd14: rom_raw = 6'd39;
      5'd15: rom_raw = 6'd41;
      5'd16: rom_raw = 6'd45;
      5'd17: rom_raw = 6'd15;
      5'd18: rom_raw = 6'd21;
      5'd19: rom_raw = 6'd8;
      5'd20: rom_raw = 6'd18;
      5'd21: rom_raw = 6'd2;
      5'd22: rom_raw = 6'd61;
      5'd23: rom_raw = 6'd56;
      5'd24: rom_raw = 6'd14;
      default: rom_raw = 6'd0;
    endcase
    rom_off = 6'(32'(rom_raw) % LANE_W);
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    offset_d = offset_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          shreg_d  = lane;
          cnt_d    = rom_off;
          offset_d = rom_off;
          state_d  = StShift;
        end
      end
      StShift: begin
`ifdef INV_ROTATOR_BARREL_EN
        shreg_d = (shreg_q >> cnt_q) | (shreg_q << (LANE_W - 32'(cnt_q)));
        cnt_d   = 6'd0;
        state_d = StDone;
`else
        if (cnt_q == 6'd0) begin
          state_d = StDone;
        end else begin
          shreg_d = {shreg_q[0], shreg_q[LANE_W-1:1]};
          cnt_d   = cnt_q - 6'd1;
        end
`endif
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      cnt_q    <= '0;
      offset_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign offset  = offset_q;
  assign rotated = shreg_q;

endmodule

// File: tb/tb_inv_rotator.sv
// Directed and randomized checks of inv_rotator against a rho-offset model derived from
// the Keccak (x,y) walk; latency expectation follows INV_ROTATOR_BARREL_EN.
module tb_inv_rotator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] lane;
  logic [4:0]  l_n;
  logic        busy;
  logic        done;
  logic [5:0]  offset;
  logic [63:0] rotated;

  int n_cmp = 0;
  int n_bad = 0;
  int rho[25];

  inv_rotator #(.LANE_W(64)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .lane    (lane),
    .l_n     (l_n),
    .busy    (busy),
    .done    (done),
    .offset  (offset),
    .rotated (rotated)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int model_off(input int idx);
    return (idx > 24) ? 0 : rho[idx];
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int r);
    return (r == 0) ? x : ((x >> r) | (x << (64 - r)));
  endfunction

  function automatic logic [63:0] rotl(input logic [63:0] x, input int r);
    return (r == 0) ? x : ((x << r) | (x >> (64 - r)));
  endfunction

  function automatic int exp_latency(input int r);
`ifdef INV_ROTATOR_BARREL_EN
    return 2;
`else
    return r + 2;
`endif
  endfunction

  // Called at posedge+1 with the DUT idle; start edge counts as edge 1.
  task automatic run_op(input string tag, input logic [63:0] ln, input int idx,
                        input logic [63:0] exp_rot);
    int n;
    int r;
    r     = model_off(idx);
    lane  = ln;
    l_n   = 5'(idx);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    check({tag, " busy"}, 64'(busy), 64'd1);
    while (!done && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " latency"}, 64'(n), 64'(exp_latency(r)));
    check({tag, " rotated"}, rotated, exp_rot);
    check({tag, " offset"}, 64'(offset), 64'(r));
    @(posedge clk); #1;
    check({tag, " done pulse"}, 64'(done), 64'd0);
    check({tag, " idle"}, 64'(busy), 64'd0);
    check({tag, " hold"}, rotated, exp_rot);
  endtask

  initial begin
    int x, y, t, tmp, seen;
    logic [63:0] v, a;

    rho[0] = 0;
    x = 1; y = 0;
    for (t = 0; t < 24; t++) begin
      rho[x + 5 * y] = ((t + 1) * (t + 2) / 2) % 64;
      tmp = x; x = y; y = (2 * tmp + 3 * y) % 5;
    end

    rst = 1'b1; start = 1'b0; lane = '0; l_n = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst rotated", rotated, 64'd0);
    check("rst offset", 64'(offset), 64'd0);

    run_op("ln1", 64'h1, 1, 64'h8000_0000_0000_0000);
    run_op("ln2", 64'h1, 2, 64'h4);
    run_op("ln0", 64'hDEAD_BEEF_0123_4567, 0, 64'hDEAD_BEEF_0123_4567);
    run_op("ln30", 64'hDEAD_BEEF_0123_4567, 30, 64'hDEAD_BEEF_0123_4567);

    // Reset beats start in the same cycle.
    rst = 1'b1; start = 1'b1; lane = 64'hFFFF; l_n = 5'd2;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst prio busy", 64'(busy), 64'd0);
    check("rst prio offset", 64'(offset), 64'd0);

    // Restart while busy is ignored; reset mid-shift aborts with no done.
    a = {$urandom, $urandom};
    lane = a; l_n = 5'd18; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int c = 1; c < 10; c++) begin
      if (c == 5) begin
        lane = ~a; l_n = 5'd2; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) seen++;
    end
    check("restart offset", 64'(offset), 64'd21);
    check("restart busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    if (done) seen++;
    check("abort busy", 64'(busy), 64'd0);
    check("abort rotated", rotated, 64'd0);
    check("abort offset", 64'(offset), 64'd0);
    check("abort no done", 64'(seen), 64'd0);
    @(posedge clk); #1;
    check("abort stays idle", 64'(done), 64'd0);

    // Round trip over every lane index with random pre-rotated lanes.
    for (int i = 0; i < 25; i++) begin
      v = {$urandom, $urandom};
      run_op($sformatf("sweep%0d", i), rotl(v, model_off(i)), i, v);
    end

    // A few random lanes and indices (including out-of-range) against the forward model.
    for (int i = 0; i < 6; i++) begin
      v = {$urandom, $urandom};
      tmp = $urandom_range(31, 0);
      run_op($sformatf("rand%0d", i), v, tmp, rotr(v, model_off(tmp)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
